// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order fetches over a req/gnt/rvalid
// memory port, buffers returned words in a credit-limited FIFO and handles jump redirects.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    input  logic        hold,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] addr_o
);

    localparam int          PW    = $clog2(DEPTH);
    localparam int          CW    = PW + 1;
    localparam int          SW    = CW + 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef logic [CW-1:0] cnt_t;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    cnt_t          outstanding_q, outstanding_d;
    cnt_t          discard_q, discard_d;
    cnt_t          count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_addr_q [DEPTH];
    logic [31:0]   fifo_inst_q [DEPTH];

    logic [SW-1:0] credit_used;
    logic [31:0]   jump_target;
    logic          grant;
    logic          drop;
    logic          push;
    logic          pop;

    // Every slot that a buffered, in-flight or to-be-dropped word may occupy holds a credit.
    assign credit_used = SW'(count_q) + SW'(outstanding_q) + SW'(discard_q);
    assign mem_req_o   = rstn & (credit_used < SW'(DEPTH));
    assign mem_addr_o  = pc_q;
    assign grant       = mem_req_o & mem_gnt_i;
    assign jump_target = jump_addr & 32'hFFFF_FFFC;

    assign drop = mem_rvalid_i & (discard_q != '0);
    assign push = mem_rvalid_i & (discard_q == '0) & ~jump;
    assign pop  = inst_valid_o & ~hold & ~jump;

    assign inst_valid_o = (count_q != '0);
    assign inst_o       = inst_valid_o ? fifo_inst_q[rd_ptr_q] : NOP;
    assign addr_o       = inst_valid_o ? fifo_addr_q[rd_ptr_q] : 32'h0;

    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + cnt_t'(grant) - cnt_t'(mem_rvalid_i);
        discard_d     = discard_q - cnt_t'(drop);
        count_d       = count_q + cnt_t'(push) - cnt_t'(pop);
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (grant) begin
            pc_d = pc_q + 32'd4;
        end
        if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // After a redirect every request still in flight is stale, including any
        // already marked for dropping, so discard simply tracks what remains outstanding.
        if (jump) begin
            pc_d      = jump_target;
            resp_pc_d = jump_target;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            discard_d = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Payload storage needs no reset; it is only observed through a nonzero count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= resp_pc_q;
            fifo_inst_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed per-cycle vector table, a double-jump
// sequence, a randomised memory/hold stream against an address scoreboard, and mid-run reset.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        hold = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] addr_o;

    int          total = 0;
    int          bad = 0;
    int          gntPct = 100;
    int          latMin = 1;
    int          latMax = 1;
    int          cyc = 0;
    logic [31:0] dataXor = 32'h0;
    logic [31:0] expNext;
    int          pops;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    typedef struct {
        logic        hold;
        logic        jump;
        logic [31:0] jaddr;
        logic        expReq;
        logic [31:0] expMemAddr;
        logic        expValid;
        logic [31:0] expAddr;
    } vec_t;
    vec_t vecs[$];

    ifu_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .jump         (jump),
        .jump_addr    (jump_addr),
        .hold         (hold),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .addr_o       (addr_o)
    );

    always #5 clk = ~clk;

    // Memory model: returns addr ^ dataXor, in order, latMin..latMax cycles after each grant.
    always @(negedge clk) begin
        cyc++;
        mem_gnt_i = ($urandom_range(99, 0) < gntPct);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = pend[0].addr ^ dataXor;
            void'(pend.pop_front());
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'hDEAD_BEEF;
        end
        #1;
        if (!rstn) begin
            pend.delete();
        end else begin
            if (mem_req_o && mem_gnt_i)
                pend.push_back('{addr: mem_addr_o, due: cyc + int'($urandom_range(latMax, latMin))});
            if (mem_rvalid_i && dut.count_q == DEPTH) begin
                bad++;
                $display("[TB] FAIL overflow: response with count=%0d, limit %0d", dut.count_q, DEPTH);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic h, input logic j, input logic [31:0] ja);
        @(negedge clk);
        rstn      = r;
        hold      = h;
        jump      = j;
        jump_addr = ja;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expReq, input logic [31:0] expMemAddr,
                               input logic expValid, input logic [31:0] expAddr);
        checkVal({name, ".req"},   {31'h0, mem_req_o},    {31'h0, expReq});
        checkVal({name, ".maddr"}, mem_addr_o,            expMemAddr);
        checkVal({name, ".valid"}, {31'h0, inst_valid_o}, {31'h0, expValid});
        checkVal({name, ".addr"},  addr_o,                expValid ? expAddr : 32'h0);
        checkVal({name, ".inst"},  inst_o,                expValid ? (expAddr ^ dataXor) : NOP);
    endtask

    task automatic addVec(input logic h, input logic j, input logic [31:0] ja, input logic req,
                          input logic [31:0] ma, input logic v, input logic [31:0] a);
        vecs.push_back('{hold: h, jump: j, jaddr: ja, expReq: req, expMemAddr: ma, expValid: v, expAddr: a});
    endtask

    task automatic runStream(input int n, input int holdPct);
        logic h;
        for (int i = 0; i < n; i++) begin
            h = ($urandom_range(99, 0) < holdPct);
            applyStimulus(1'b1, h, 1'b0, 32'h0);
            if (inst_valid_o) begin
                checkVal("stream.addr", addr_o, expNext);
                checkVal("stream.inst", inst_o, expNext ^ dataXor);
                if (!hold) begin
                    expNext += 32'd4;
                    pops++;
                end
            end else begin
                checkVal("stream.idle", inst_o, NOP);
            end
        end
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("reset", 1'b0, RESET_PC, 1'b0, 32'h0);

        // Cycle 0 = first cycle with rstn high; gnt=1, latency 1
        addVec(0, 0, 32'h0,   1, 32'h00,  0, 32'h0);
        addVec(0, 0, 32'h0,   1, 32'h04,  0, 32'h0);
        addVec(0, 0, 32'h0,   1, 32'h08,  1, 32'h00);
        addVec(0, 0, 32'h0,   1, 32'h0C,  1, 32'h04);
        addVec(0, 0, 32'h0,   1, 32'h10,  1, 32'h08);
        addVec(0, 0, 32'h0,   1, 32'h14,  1, 32'h0C);
        addVec(1, 0, 32'h0,   1, 32'h18,  1, 32'h10);
        addVec(1, 0, 32'h0,   1, 32'h1C,  1, 32'h10);
        addVec(1, 0, 32'h0,   0, 32'h20,  1, 32'h10);
        addVec(1, 0, 32'h0,   0, 32'h20,  1, 32'h10);
        addVec(0, 0, 32'h0,   0, 32'h20,  1, 32'h10);
        addVec(0, 0, 32'h0,   1, 32'h20,  1, 32'h14);
        addVec(0, 0, 32'h0,   1, 32'h24,  1, 32'h18);
        addVec(0, 0, 32'h0,   1, 32'h28,  1, 32'h1C);
        addVec(0, 1, 32'h103, 1, 32'h2C,  1, 32'h20);
        addVec(0, 0, 32'h0,   1, 32'h100, 0, 32'h0);
        addVec(0, 0, 32'h0,   1, 32'h104, 0, 32'h0);
        addVec(0, 0, 32'h0,   1, 32'h108, 1, 32'h100);
        addVec(0, 0, 32'h0,   1, 32'h10C, 1, 32'h104);
        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(1'b1, vecs[k].hold, vecs[k].jump, vecs[k].jaddr);
            checkOutput($sformatf("vec%0d", k), vecs[k].expReq, vecs[k].expMemAddr,
                        vecs[k].expValid, vecs[k].expAddr);
        end

        // Jump with a grant and a response in the same cycle, then a second jump
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h180);
        checkOutput("dj0", 1'b1, 32'h110, 1'b1, 32'h108);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h200);
        checkOutput("dj1", 1'b1, 32'h180, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("dj2", 1'b1, 32'h200, 1'b0, 32'h0);
        checkVal("dj2.discard", 32'(dut.discard_q), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("dj3", 1'b1, 32'h204, 1'b0, 32'h0);
        checkVal("dj3.discard", 32'(dut.discard_q), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("dj4", 1'b1, 32'h208, 1'b1, 32'h200);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("dj5", 1'b1, 32'h20C, 1'b1, 32'h204);
        checkVal("dj5.discard", 32'(dut.discard_q), 32'd0);

        // Random grant and latency with hold toggling
        dataXor = 32'h5A5A_0F0F;
        gntPct  = 50;
        latMin  = 1;
        latMax  = 5;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        expNext = RESET_PC;
        pops    = 0;
        runStream(300, 30);
        checkVal("stream.progress", {31'h0, pops >= 30}, 32'd1);

        // Reset pulsed mid-stream, then fetch restarts at RESET_PC
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("midrst", 1'b0, RESET_PC, 1'b0, 32'h0);
        expNext = RESET_PC;
        pops    = 0;
        runStream(150, 20);
        checkVal("restart.progress", {31'h0, pops >= 10}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
